mem_port_arbiter: RTL

- Shares the single 32-bit memory port between two requesters: M0, the multi-cycle CPU data/fetch port wrapped with a valid/ready shim, and M1, a debug/program loader.
- Sequences one transaction at a time (accept, issue, wait, respond) against a memory with a fixed read latency.
- Sits between the requesters and the unified RAM/MMIO decoder.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_rr_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for mem_port_arbiter: FSM encoding, master ids,
// wait-counter width and the counter preload helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic MID_M0 = 1'b0;
    localparam logic MID_M1 = 1'b1;

    localparam int CNT_W = 3;

    // WAIT counts down to zero, so the preload is one less than the latency.
    function automatic logic [CNT_W-1:0] wait_load(input int lat);
        return (lat > 0) ? CNT_W'(lat - 1) : '0;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way picker. Round-robin by default; with MEM_ARB_FIXED_PRIO_EN
// defined, M0 always wins a tie and last_grant is ignored.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant    = 2'b00;
        grant_id = MID_M0;
        if (valid[0]) begin
            grant    = 2'b01;
            grant_id = MID_M0;
        end else if (valid[1]) begin
            grant    = 2'b10;
            grant_id = MID_M1;
        end
    end
`else
    // On a tie M0 wins only if M1 was served last.
    always_comb begin
        grant    = 2'b00;
        grant_id = MID_M0;
        if (valid[0] && (!valid[1] || last_grant == MID_M1)) begin
            grant    = 2'b01;
            grant_id = MID_M0;
        end else if (valid[1]) begin
            grant    = 2'b10;
            grant_id = MID_M1;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two valid/ready masters, one transaction at a time
// (accept, issue, wait, respond). Define MEM_ARB_FIXED_PRIO_EN for strict M0 priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req_valid,
    output logic                m0_req_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_rsp_valid,
    output logic [DATA_W-1:0]   m0_rsp_rdata,

    input  logic                m1_req_valid,
    output logic                m1_req_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_rsp_valid,
    output logic [DATA_W-1:0]   m1_rsp_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wenable,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int WSTRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(LATENCY);

    state_t               state_reg, state_next;
    logic                 owner_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [WSTRB_W-1:0]   wstrb_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [DATA_W-1:0]    rdata_reg;

    logic [1:0]           pick_valid;
    logic [1:0]           pick_grant;
    logic                 pick_id;
    logic                 pick_last;
    logic                 accept;
    logic                 capture;

    // Requests are only visible to the picker in IDLE, so ready is never raised elsewhere.
    assign pick_valid = (state_reg == IDLE) ? {m1_req_valid, m0_req_valid} : 2'b00;

    mem_arb_rr_pick u_pick (
        .valid      (pick_valid),
        .last_grant (pick_last),
        .grant      (pick_grant),
        .grant_id   (pick_id)
    );

    assign m0_req_ready = pick_grant[0];
    assign m1_req_ready = pick_grant[1];
    assign accept       = |pick_grant;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_last = MID_M1;
`else
    logic last_grant_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= MID_M1;
        end else if (accept) begin
            last_grant_reg <= pick_id;
        end
    end

    assign pick_last = last_grant_reg;
`endif

    assign capture = ((state_reg == ISSUE) && (LATENCY == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == '0));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt_reg == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            owner_reg <= MID_M0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg <= pick_id;
                addr_reg  <= (pick_id == MID_M1) ? m1_addr  : m0_addr;
                wdata_reg <= (pick_id == MID_M1) ? m1_wdata : m0_wdata;
                wstrb_reg <= (pick_id == MID_M1) ? m1_wstrb : m0_wstrb;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= CNT_LOAD;
            end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            // Writes report zero read data.
            if (capture) begin
                rdata_reg <= (wstrb_reg == '0) ? mem_rdata : '0;
            end
        end
    end

    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;
    assign mem_wenable = (state_reg == ISSUE) ? wstrb_reg : '0;

    assign m0_rsp_valid = (state_reg == RESP) && (owner_reg == MID_M0);
    assign m1_rsp_valid = (state_reg == RESP) && (owner_reg == MID_M1);
    assign m0_rsp_rdata = m0_rsp_valid ? rdata_reg : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? rdata_reg : '0;

    assign busy = (state_reg != IDLE);

endmodule
